// File: rtl/mem_stage_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_dmem_ctrl
//
// MEM-stage data-memory access controller. Sits between the EX/MEM pipeline
// register and the MEM/WB register. It turns a single-cycle load/store into a
// req/ack handshake with a variable-latency data memory. The pipeline stalls
// until the access completes. Misaligned and timed-out accesses are flagged.
//
// Access sequence: IDLE -> WAIT -> DONE for an aligned access, and
// IDLE -> DONE for a misaligned one. A non-memory instruction stays in IDLE
// and costs no extra cycles.
//
// Parameters:
//   TIMEOUT_CYCLES  max WAIT cycles without dmem_ack before abandoning (2..255)
//   ERR_RDATA       load data returned on a timed-out or misaligned load
//
// Optional feature (macro DMEM_PERF_CNT_EN):
//   When defined, perf_stall_cycles counts cycles with stall_MEM=1 and
//   saturates at all-ones. When undefined, perf_stall_cycles is tied to 0.
//
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   mem_read_MEM             load in MEM stage
//   mem_write_MEM            store in MEM stage (wins if both are high)
//   ALU_result_MEM           byte address
//   store_data_MEM           store data
//   Datamem_Read_Data_MEM    load data to MEM/WB, meaningful in DONE
//   stall_MEM                freeze the earlier stages; MEM/WB holds while high
//   dmem_req/we/addr/wdata   registered memory request
//   dmem_rdata, dmem_ack     memory response, ack is a one-cycle pulse
//   misalign_err, bus_err    sticky error flags, cleared only by reset
//   perf_stall_cycles        stall-cycle counter
// ---------------------------------------------------------------------------
module mem_stage_dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic [31:0] ALU_result_MEM,
  input  logic [31:0] store_data_MEM,
  output logic [31:0] Datamem_Read_Data_MEM,
  output logic        stall_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [31:0] perf_stall_cycles
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic access;
  logic aligned;

  assign access  = mem_read_MEM | mem_write_MEM;
  assign aligned = (ALU_result_MEM[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q;
    cnt_d      = cnt_q;
    stall_MEM  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          stall_MEM = 1'b1;
          if (aligned) begin
            req_d   = 1'b1;
            we_d    = mem_write_MEM;
            addr_d  = {ALU_result_MEM[31:2], 2'b00};
            wdata_d = store_data_MEM;
            cnt_d   = 8'd0;
            state_d = StWait;
          end else begin
            misalign_d = 1'b1;
            rdata_d    = ERR_RDATA;
            state_d    = StDone;
          end
        end
      end

      StWait: begin
        stall_MEM = 1'b1;
        if (dmem_ack) begin
          // Ack beats a coincident timeout.
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = StDone;
          if (!we_q) begin
            rdata_d = dmem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = ERR_RDATA;
          cnt_d     = 8'd0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StDone: begin
        // Pipeline advances at the end of this cycle.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dmem_req              = req_q;
  assign dmem_we               = we_q;
  assign dmem_addr             = addr_q;
  assign dmem_wdata            = wdata_q;
  assign Datamem_Read_Data_MEM = rdata_q;
  assign misalign_err          = misalign_q;
  assign bus_err               = bus_err_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 32'h0;
    end else if (stall_MEM && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Scoreboard bench for mem_stage_dmem_ctrl. The driver pushes the expected
// completion of each access; the monitor pops and compares when the DUT
// reaches the cycle where stall_MEM drops with the access still presented.
module tb_mem_stage_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_read_MEM;
  logic        mem_write_MEM;
  logic [31:0] ALU_result_MEM;
  logic [31:0] store_data_MEM;
  logic [31:0] Datamem_Read_Data_MEM;
  logic        stall_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        misalign_err;
  logic        bus_err;
  logic [31:0] perf_stall_cycles;

  mem_stage_dmem_ctrl #(
    .TIMEOUT_CYCLES(16),
    .ERR_RDATA     (32'h0000_0000)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .mem_read_MEM         (mem_read_MEM),
    .mem_write_MEM        (mem_write_MEM),
    .ALU_result_MEM       (ALU_result_MEM),
    .store_data_MEM       (store_data_MEM),
    .Datamem_Read_Data_MEM(Datamem_Read_Data_MEM),
    .stall_MEM            (stall_MEM),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_rdata           (dmem_rdata),
    .dmem_ack             (dmem_ack),
    .misalign_err         (misalign_err),
    .bus_err              (bus_err),
    .perf_stall_cycles    (perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    int          stall;
    int          reqc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mis;
    logic        bus;
    logic [31:0] perf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   perf_acc = 0;

  // Memory responder configuration.
  int          resp_wait = 0;
  logic [31:0] resp_data = 32'h0;
  logic        force_ack = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Responder: ack on WAIT cycle resp_wait (1-based); 0 means never.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      if (dmem_req) begin
        wait_cnt++;
        if (wait_cnt == resp_wait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = resp_data;
        end
      end else begin
        wait_cnt = 0;
      end
      if (force_ack) begin
        dmem_ack   = 1'b1;
        dmem_rdata = resp_data;
      end
    end
  end

  // Monitor: accumulates stall/req cycles per access and scores completions.
  initial begin
    int          stall_cnt;
    int          req_cnt;
    logic        seen_we;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    exp_t        e;
    stall_cnt  = 0;
    req_cnt    = 0;
    seen_we    = 1'b0;
    seen_addr  = 32'h0;
    seen_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_cnt = 0;
        req_cnt   = 0;
      end else if (mem_read_MEM || mem_write_MEM) begin
        if (stall_MEM) begin
          stall_cnt++;
          if (dmem_req) begin
            req_cnt++;
            seen_we    = dmem_we;
            seen_addr  = dmem_addr;
            seen_wdata = dmem_wdata;
          end
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = exp_q.pop_front();
          check32({e.name, "_rdata"}, Datamem_Read_Data_MEM, e.rdata);
          check32({e.name, "_stall_cycles"}, 32'(stall_cnt), 32'(e.stall));
          check32({e.name, "_req_cycles"}, 32'(req_cnt), 32'(e.reqc));
          check32({e.name, "_req_done"}, {31'h0, dmem_req}, 32'h0);
          check32({e.name, "_misalign_err"}, {31'h0, misalign_err}, {31'h0, e.mis});
          check32({e.name, "_bus_err"}, {31'h0, bus_err}, {31'h0, e.bus});
          check32({e.name, "_perf"}, perf_stall_cycles, e.perf);
          if (e.reqc > 0) begin
            check32({e.name, "_we"}, {31'h0, seen_we}, {31'h0, e.we});
            check32({e.name, "_addr"}, seen_addr, e.addr);
            if (e.we) check32({e.name, "_wdata"}, seen_wdata, e.wdata);
          end
          stall_cnt = 0;
          req_cnt   = 0;
        end
      end else begin
        check32("nonmem_stall", {31'h0, stall_MEM}, 32'h0);
        stall_cnt = 0;
        req_cnt   = 0;
      end
    end
  end

  task automatic mem_op(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int wait_n, input logic [31:0] ack_data,
                        input logic [31:0] exp_rdata, input int exp_stall,
                        input int exp_reqc, input logic exp_mis, input logic exp_bus);
    exp_t e;
    int   n;
    perf_acc += exp_stall;
    e.name  = name;
    e.rdata = exp_rdata;
    e.stall = exp_stall;
    e.reqc  = exp_reqc;
    e.we    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.mis   = exp_mis;
    e.bus   = exp_bus;
`ifdef DMEM_PERF_CNT_EN
    e.perf  = 32'(perf_acc);
`else
    e.perf  = 32'h0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    resp_wait      = wait_n;
    resp_data      = ack_data;
    mem_read_MEM   = rd;
    mem_write_MEM  = wr;
    ALU_result_MEM = addr;
    store_data_MEM = wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_MEM) break;
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no completion after %0d cycles expected DONE", name, n);
        break;
      end
    end
  endtask

  task automatic nonmem;
    @(posedge clk);
    #1;
    mem_read_MEM   = 1'b0;
    mem_write_MEM  = 1'b0;
    ALU_result_MEM = 32'h0000_0ABC;
    store_data_MEM = 32'h0;
  endtask

  initial begin
    reset          = 1'b0;
    mem_read_MEM   = 1'b0;
    mem_write_MEM  = 1'b0;
    ALU_result_MEM = 32'h0;
    store_data_MEM = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check32("rst_req", {31'h0, dmem_req}, 32'h0);
    check32("rst_we", {31'h0, dmem_we}, 32'h0);
    check32("rst_addr", dmem_addr, 32'h0);
    check32("rst_wdata", dmem_wdata, 32'h0);
    check32("rst_rdata", Datamem_Read_Data_MEM, 32'h0);
    check32("rst_flags", {30'h0, misalign_err, bus_err}, 32'h0);
    check32("rst_perf", perf_stall_cycles, 32'h0);
    check32("rst_stall", {31'h0, stall_MEM}, 32'h0);

    //     name        rd    wr    addr          wdata         wait ackdata       exp_rdata  st rq mis  bus
    mem_op("load10",   1'b1, 1'b0, 32'h0000_0010, 32'h0,       1,  32'hCAFE_F00D, 32'hCAFE_F00D, 2, 1, 1'b0, 1'b0);
    mem_op("store24",  1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 4, 32'h9999_9999, 32'hCAFE_F00D, 5, 4, 1'b0, 1'b0);
    nonmem();
    mem_op("load100",  1'b1, 1'b0, 32'h0000_0100, 32'h0,       2,  32'hA5A5_0001, 32'hA5A5_0001, 3, 2, 1'b0, 1'b0);
    mem_op("load104",  1'b1, 1'b0, 32'h0000_0104, 32'h0,       1,  32'h0BAD_BEEF, 32'h0BAD_BEEF, 2, 1, 1'b0, 1'b0);
    nonmem();
    mem_op("load108",  1'b1, 1'b0, 32'h0000_0108, 32'h0,       3,  32'h1111_2222, 32'h1111_2222, 4, 3, 1'b0, 1'b0);
    mem_op("rdwr30",   1'b1, 1'b1, 32'h0000_0030, 32'hDEAD_0030, 1, 32'hFFFF_FFFF, 32'h1111_2222, 2, 1, 1'b0, 1'b0);
    mem_op("ack16",    1'b1, 1'b0, 32'h0000_0040, 32'h0,       16, 32'h5555_AAAA, 32'h5555_AAAA, 17, 16, 1'b0, 1'b0);
    mem_op("tmo44",    1'b1, 1'b0, 32'h0000_0044, 32'h0,       0,  32'h0,         32'h0000_0000, 17, 16, 1'b0, 1'b1);
    mem_op("mis13",    1'b1, 1'b0, 32'h0000_0013, 32'h0,       1,  32'h3333_3333, 32'h0000_0000, 1, 0, 1'b1, 1'b1);
    mem_op("load50",   1'b1, 1'b0, 32'h0000_0050, 32'h0,       1,  32'h7777_8888, 32'h7777_8888, 2, 1, 1'b1, 1'b1);

    // Reset in the middle of WAIT, then a stray ack.
    @(posedge clk);
    #1;
    resp_wait      = 0;
    mem_read_MEM   = 1'b1;
    mem_write_MEM  = 1'b0;
    ALU_result_MEM = 32'h0000_0060;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("midwait_req", {31'h0, dmem_req}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check32("rst_mid_req", {31'h0, dmem_req}, 32'h0);
    check32("rst_mid_flags", {30'h0, misalign_err, bus_err}, 32'h0);
    check32("rst_mid_rdata", Datamem_Read_Data_MEM, 32'h0);
    check32("rst_mid_perf", perf_stall_cycles, 32'h0);
    mem_read_MEM = 1'b0;
    perf_acc     = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    resp_data = 32'hFFFF_0000;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    check32("late_ack_req", {31'h0, dmem_req}, 32'h0);
    check32("late_ack_rdata", Datamem_Read_Data_MEM, 32'h0);
    check32("late_ack_flags", {30'h0, misalign_err, bus_err}, 32'h0);
    mem_op("load70",   1'b1, 1'b0, 32'h0000_0070, 32'h0,       2,  32'h1357_9BDF, 32'h1357_9BDF, 3, 2, 1'b0, 1'b0);
    nonmem();
    repeat (3) @(posedge clk);
    check32("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
